// File: rtl/ddr3_axi_arb2_pkg.sv
// Shared AXI encodings and defaults for the two-requester DDR3 port arbiter.
package ddr3_axi_arb2_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned ID_W_DEFAULT   = 4;
  localparam int unsigned ADDR_W_DEFAULT = 28;

  typedef enum logic {
    REQ_S0 = 1'b0,
    REQ_S1 = 1'b1
  } req_e;

  function automatic req_e other_req(input req_e r);
    return (r == REQ_S0) ? REQ_S1 : REQ_S0;
  endfunction

endpackage

// File: rtl/ddr3_axi_arb2_rr_addr_arb.sv
// Two-way round-robin address-channel arbiter with a one-deep output register.
module axi_rr_addr_arb
  import ddr3_axi_arb2_pkg::*;
#(
  parameter int unsigned FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    s_valid,
  output logic [1:0]    s_ready,
  input  logic [2*FW-1:0] s_fields,
  input  logic          block,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [FW-1:0] m_fields,
  output logic          m_idx,
  output logic          grant,
  output logic          grant_idx
);

  req_e          ptr_q, ptr_d;
  req_e          gnt_sel;
  logic          m_valid_q, m_valid_d;
  logic [FW-1:0] fields_q, fields_d;
  logic          idx_q, idx_d;
  logic          open;

  always_comb begin
    open      = (!m_valid_q || m_ready) && !block && !rst;
    gnt_sel   = (s_valid == 2'b11) ? ptr_q : (s_valid[1] ? REQ_S1 : REQ_S0);
    grant     = open && (s_valid != 2'b00);
    grant_idx = gnt_sel;
    s_ready   = '0;
    if (grant) s_ready = (gnt_sel == REQ_S1) ? 2'b10 : 2'b01;

    // Pointer only advances when both requesters contended for the slot.
    ptr_d = ptr_q;
    if (grant && s_valid == 2'b11) ptr_d = other_req(ptr_q);

    m_valid_d = m_valid_q;
    fields_d  = fields_q;
    idx_d     = idx_q;
    if (grant) begin
      m_valid_d = 1'b1;
      fields_d  = (gnt_sel == REQ_S1) ? s_fields[2*FW-1:FW] : s_fields[FW-1:0];
      idx_d     = gnt_sel;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= REQ_S0;
      m_valid_q <= 1'b0;
      fields_q  <= '0;
      idx_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      m_valid_q <= m_valid_d;
      fields_q  <= fields_d;
      idx_q     <= idx_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_fields = fields_q;
  assign m_idx    = idx_q;

endmodule

// File: rtl/ddr3_axi_arb2.sv
// Shares the single DDR3 controller AXI port between two requesters (S0, S1).
module ddr3_axi_arb2
  import ddr3_axi_arb2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STROBES       = DATA_WIDTH / 8,
  parameter int unsigned ADDRESS_WIDTH = ADDR_W_DEFAULT,
  parameter int unsigned ID_WIDTH      = ID_W_DEFAULT,
  parameter int unsigned WFIFO_DEPTH   = 4
) (
  input  logic                         mem_clock,
  input  logic                         mem_reset,
  input  logic [1:0]                   s_awvalid,
  output logic [1:0]                   s_awready,
  input  logic [2*ADDRESS_WIDTH-1:0]   s_awaddr,
  input  logic [2*(ID_WIDTH-1)-1:0]    s_awid,
  input  logic [15:0]                  s_awlen,
  input  logic [3:0]                   s_awburst,
  input  logic [1:0]                   s_wvalid,
  output logic [1:0]                   s_wready,
  input  logic [1:0]                   s_wlast,
  input  logic [2*STROBES-1:0]         s_wstrb,
  input  logic [2*DATA_WIDTH-1:0]      s_wdata,
  output logic [1:0]                   s_bvalid,
  input  logic [1:0]                   s_bready,
  output logic [1:0]                   s_bresp,
  output logic [ID_WIDTH-2:0]          s_bid,
  input  logic [1:0]                   s_arvalid,
  output logic [1:0]                   s_arready,
  input  logic [2*ADDRESS_WIDTH-1:0]   s_araddr,
  input  logic [2*(ID_WIDTH-1)-1:0]    s_arid,
  input  logic [15:0]                  s_arlen,
  input  logic [3:0]                   s_arburst,
  output logic [1:0]                   s_rvalid,
  input  logic [1:0]                   s_rready,
  output logic                         s_rlast,
  output logic [1:0]                   s_rresp,
  output logic [ID_WIDTH-2:0]          s_rid,
  output logic [DATA_WIDTH-1:0]        s_rdata,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [ADDRESS_WIDTH-1:0]     m_awaddr,
  output logic [ID_WIDTH-1:0]          m_awid,
  output logic [7:0]                   m_awlen,
  output logic [1:0]                   m_awburst,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  output logic                         m_wlast,
  output logic [STROBES-1:0]           m_wstrb,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  input  logic [1:0]                   m_bresp,
  input  logic [ID_WIDTH-1:0]          m_bid,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  output logic [ADDRESS_WIDTH-1:0]     m_araddr,
  output logic [ID_WIDTH-1:0]          m_arid,
  output logic [7:0]                   m_arlen,
  output logic [1:0]                   m_arburst,
  input  logic                         m_rvalid,
  output logic                         m_rready,
  input  logic                         m_rlast,
  input  logic [1:0]                   m_rresp,
  input  logic [ID_WIDTH-1:0]          m_rid,
  input  logic [DATA_WIDTH-1:0]        m_rdata
);

  localparam int unsigned SIW = ID_WIDTH - 1;
  localparam int unsigned FW  = SIW + ADDRESS_WIDTH + 8 + 2;
  localparam int unsigned PW  = $clog2(WFIFO_DEPTH);

  logic [2*FW-1:0] aw_fields, ar_fields;
  logic [FW-1:0]   aw_m_fields, ar_m_fields;
  logic [SIW-1:0]  aw_id_lo, ar_id_lo;
  logic            aw_m_idx, ar_m_idx;
  logic            aw_grant, aw_grant_idx;
  logic            ar_grant, ar_grant_idx;

  logic            fifo_q [WFIFO_DEPTH];
  logic            fifo_d [WFIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            wfifo_full, wfifo_empty, head, push, pop;

  always_comb begin
    aw_fields = '0;
    ar_fields = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      aw_fields[i*FW +: FW] = {s_awid[i*SIW +: SIW], s_awaddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                               s_awlen[i*8 +: 8], s_awburst[i*2 +: 2]};
      ar_fields[i*FW +: FW] = {s_arid[i*SIW +: SIW], s_araddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                               s_arlen[i*8 +: 8], s_arburst[i*2 +: 2]};
    end
  end

  axi_rr_addr_arb #(.FW(FW)) u_aw_arb (
    .clk       (mem_clock),
    .rst       (mem_reset),
    .s_valid   (s_awvalid),
    .s_ready   (s_awready),
    .s_fields  (aw_fields),
    .block     (wfifo_full),
    .m_valid   (m_awvalid),
    .m_ready   (m_awready),
    .m_fields  (aw_m_fields),
    .m_idx     (aw_m_idx),
    .grant     (aw_grant),
    .grant_idx (aw_grant_idx)
  );

  axi_rr_addr_arb #(.FW(FW)) u_ar_arb (
    .clk       (mem_clock),
    .rst       (mem_reset),
    .s_valid   (s_arvalid),
    .s_ready   (s_arready),
    .s_fields  (ar_fields),
    .block     (1'b0),
    .m_valid   (m_arvalid),
    .m_ready   (m_arready),
    .m_fields  (ar_m_fields),
    .m_idx     (ar_m_idx),
    .grant     (ar_grant),
    .grant_idx (ar_grant_idx)
  );

  assign {aw_id_lo, m_awaddr, m_awlen, m_awburst} = aw_m_fields;
  assign {ar_id_lo, m_araddr, m_arlen, m_arburst} = ar_m_fields;
  assign m_awid = {aw_m_idx, aw_id_lo};
  assign m_arid = {ar_m_idx, ar_id_lo};

  // Grant-order FIFO: W beats follow the order in which AWs were accepted.
  always_comb begin
    wfifo_full  = (cnt_q == (PW+1)'(WFIFO_DEPTH));
    wfifo_empty = (cnt_q == '0);
    head        = fifo_q[rd_ptr_q];

    m_wvalid = 1'b0;
    s_wready = '0;
    m_wdata  = head ? s_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_wdata[DATA_WIDTH-1:0];
    m_wstrb  = head ? s_wstrb[2*STROBES-1:STROBES]       : s_wstrb[STROBES-1:0];
    m_wlast  = head ? s_wlast[1] : s_wlast[0];
    if (!wfifo_empty && !mem_reset) begin
      m_wvalid       = s_wvalid[head];
      s_wready[head] = m_wready;
    end

    push = aw_grant;
    pop  = m_wvalid && m_wready && m_wlast;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = aw_grant_idx;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge mem_clock or posedge mem_reset) begin
    if (mem_reset) begin
      for (int unsigned i = 0; i < WFIFO_DEPTH; i++) fifo_q[i] <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    s_bvalid = '0;
    s_rvalid = '0;
    if (!mem_reset) begin
      s_bvalid[m_bid[ID_WIDTH-1]] = m_bvalid;
      s_rvalid[m_rid[ID_WIDTH-1]] = m_rvalid;
    end
    m_bready = !mem_reset && s_bready[m_bid[ID_WIDTH-1]];
    m_rready = !mem_reset && s_rready[m_rid[ID_WIDTH-1]];
    s_bid    = m_bid[SIW-1:0];
    s_bresp  = m_bresp;
    s_rid    = m_rid[SIW-1:0];
    s_rresp  = m_rresp;
    s_rlast  = m_rlast;
    s_rdata  = m_rdata;
  end

endmodule

// File: tb/tb_ddr3_axi_arb2.sv
// Randomized bench for ddr3_axi_arb2 against a transaction-level reference model.
module tb_ddr3_axi_arb2;
  import ddr3_axi_arb2_pkg::*;

  localparam int DW = 32, SW = 4, AW = 28, IW = 4, SIW = 3, DEPTH = 4;

  logic mem_clock = 1'b0;
  logic mem_reset = 1'b1;
  always #5 mem_clock = ~mem_clock;

  logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_bresp, s_rresp;
  logic [2*AW-1:0] s_awaddr, s_araddr;
  logic [2*SIW-1:0] s_awid, s_arid;
  logic [15:0] s_awlen, s_arlen;
  logic [3:0] s_awburst, s_arburst;
  logic [2*SW-1:0] s_wstrb;
  logic [2*DW-1:0] s_wdata;
  logic [SIW-1:0] s_bid, s_rid;
  logic s_rlast;
  logic [DW-1:0] s_rdata;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [IW-1:0] m_awid, m_arid, m_bid, m_rid;
  logic [7:0] m_awlen, m_arlen;
  logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_wdata, m_rdata;

  ddr3_axi_arb2 #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .WFIFO_DEPTH(DEPTH)) dut (
    .mem_clock(mem_clock), .mem_reset(mem_reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rresp(s_rresp), .s_rid(s_rid),
    .s_rdata(s_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rresp(m_rresp), .m_rid(m_rid),
    .m_rdata(m_rdata)
  );

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending address slots and the outstanding-write order.
  typedef struct {
    logic idx;
    logic [SIW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0] len;
    logic [1:0] burst;
  } addr_t;
  addr_t awq[$], arq[$];
  int wfo[$];
  int ptr_aw, ptr_ar;

  // Requester drivers
  bit aw_act[2], ar_act[2], w_act[2];
  logic [AW-1:0] aw_addr[2], ar_addr[2];
  logic [SIW-1:0] aw_id[2], ar_id[2];
  logic [7:0] aw_len[2], ar_len[2];
  logic [1:0] aw_burst[2], ar_burst[2];
  logic [DW-1:0] w_data[2];
  logic [SW-1:0] w_strb[2];
  bit w_last[2];
  int w_beat[2];
  int w_pend[2][$];
  bit aw_hs[2], ar_hs[2], w_hs[2];
  int w_hold, aw_stall;

  function automatic logic [1:0] rand_burst();
    case ($urandom_range(0, 2))
      0: return BURST_FIXED;
      1: return BURST_INCR;
      default: return BURST_WRAP;
    endcase
  endfunction

  task automatic drive();
    s_awvalid = {aw_act[1], aw_act[0]};
    s_awaddr = {aw_addr[1], aw_addr[0]}; s_awid = {aw_id[1], aw_id[0]};
    s_awlen = {aw_len[1], aw_len[0]}; s_awburst = {aw_burst[1], aw_burst[0]};
    s_arvalid = {ar_act[1], ar_act[0]};
    s_araddr = {ar_addr[1], ar_addr[0]}; s_arid = {ar_id[1], ar_id[0]};
    s_arlen = {ar_len[1], ar_len[0]}; s_arburst = {ar_burst[1], ar_burst[0]};
    s_wvalid = {w_act[1], w_act[0]};
    s_wdata = {w_data[1], w_data[0]}; s_wstrb = {w_strb[1], w_strb[0]};
    s_wlast = {w_act[1] & w_last[1], w_act[0] & w_last[0]};
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      aw_act[i] = 0; ar_act[i] = 0; w_act[i] = 0; w_last[i] = 0; w_beat[i] = 0;
      aw_addr[i] = '0; ar_addr[i] = '0; aw_id[i] = '0; ar_id[i] = '0;
      aw_len[i] = '0; ar_len[i] = '0; aw_burst[i] = '0; ar_burst[i] = '0;
      w_data[i] = '0; w_strb[i] = '0;
      aw_hs[i] = 0; ar_hs[i] = 0; w_hs[i] = 0;
      w_pend[i].delete();
    end
    awq.delete(); arq.delete(); wfo.delete();
    ptr_aw = 0; ptr_ar = 0; w_hold = 0; aw_stall = 0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bid = '0; m_bresp = '0; s_bready = '0;
    m_rvalid = 0; m_rid = '0; m_rresp = '0; m_rlast = 0; m_rdata = '0; s_rready = '0;
    drive();
  endtask

  task automatic check_in_reset(input string pfx);
    check_eq({pfx, "_s_awready"}, s_awready, 2'b00);
    check_eq({pfx, "_s_arready"}, s_arready, 2'b00);
    check_eq({pfx, "_s_wready"}, s_wready, 2'b00);
    check_eq({pfx, "_m_awvalid"}, m_awvalid, 1'b0);
    check_eq({pfx, "_m_arvalid"}, m_arvalid, 1'b0);
    check_eq({pfx, "_m_wvalid"}, m_wvalid, 1'b0);
    check_eq({pfx, "_s_bvalid"}, s_bvalid, 2'b00);
    check_eq({pfx, "_s_rvalid"}, s_rvalid, 2'b00);
  endtask

  task automatic new_stimulus();
    for (int i = 0; i < 2; i++) begin
      if (aw_hs[i]) begin aw_act[i] = 0; w_pend[i].push_back(int'(aw_len[i])); end
      if (ar_hs[i]) ar_act[i] = 0;
      if (w_hs[i]) begin
        w_act[i] = 0;
        if (w_last[i]) begin void'(w_pend[i].pop_front()); w_beat[i] = 0; end
        else w_beat[i]++;
      end
      if (!aw_act[i] && w_pend[i].size() < 8 && $urandom_range(0, 2) == 0) begin
        aw_act[i] = 1; aw_addr[i] = AW'($urandom); aw_id[i] = SIW'($urandom);
        aw_len[i] = ($urandom_range(0, 5) == 0) ? 8'd7 : 8'($urandom_range(0, 3));
        aw_burst[i] = rand_burst();
      end
      if (!ar_act[i] && $urandom_range(0, 2) == 0) begin
        ar_act[i] = 1; ar_addr[i] = AW'($urandom); ar_id[i] = SIW'($urandom);
        ar_len[i] = 8'($urandom); ar_burst[i] = rand_burst();
      end
      if (!w_act[i] && w_pend[i].size() > 0 && w_hold == 0 && $urandom_range(0, 3) != 0) begin
        w_act[i] = 1; w_data[i] = $urandom; w_strb[i] = SW'($urandom);
        w_last[i] = (w_beat[i] == w_pend[i][0]);
      end
    end
    if (w_hold > 0) w_hold--;
    else if ($urandom_range(0, 59) == 0) w_hold = 30;
    if (aw_stall > 0) begin aw_stall--; m_awready = 0; end
    else if ($urandom_range(0, 39) == 0) begin aw_stall = 12; m_awready = 0; end
    else m_awready = ($urandom_range(0, 3) != 0);
    m_wready = ($urandom_range(0, 3) != 0);
    m_arready = ($urandom_range(0, 2) != 0);
    m_bvalid = $urandom_range(0, 1); m_bid = IW'($urandom); m_bresp = 2'($urandom); s_bready = 2'($urandom);
    m_rvalid = $urandom_range(0, 1); m_rid = IW'($urandom); m_rresp = 2'($urandom);
    m_rlast = $urandom_range(0, 1); m_rdata = $urandom; s_rready = 2'($urandom);
    drive();
  endtask

  task automatic check_and_model();
    bit aw_open, ar_open, aw_g, ar_g, exp_mwv;
    int aw_win, ar_win, h;
    logic [1:0] exp_r, exp_wr;
    addr_t e;
    // AW
    aw_open = (awq.size() == 0 || m_awready) && wfo.size() < DEPTH;
    aw_g = aw_open && s_awvalid != 2'b00;
    aw_win = (s_awvalid == 2'b11) ? ptr_aw : (s_awvalid[1] ? 1 : 0);
    exp_r = aw_g ? 2'(1 << aw_win) : 2'b00;
    check_eq("s_awready", s_awready, exp_r);
    check_eq("m_awvalid", m_awvalid, awq.size() != 0);
    if (awq.size() != 0)
      check_eq("m_aw_fields", {m_awid, m_awaddr, m_awlen, m_awburst},
               {awq[0].idx, awq[0].id, awq[0].addr, awq[0].len, awq[0].burst});
    // W
    exp_wr = 2'b00; exp_mwv = 0; h = 0;
    if (wfo.size() != 0) begin
      h = wfo[0];
      exp_wr = m_wready ? 2'(1 << h) : 2'b00;
      exp_mwv = s_wvalid[h];
    end
    check_eq("s_wready", s_wready, exp_wr);
    check_eq("m_wvalid", m_wvalid, exp_mwv);
    if (exp_mwv)
      check_eq("m_w_fields", {m_wdata, m_wstrb, m_wlast},
               {s_wdata[h*DW +: DW], s_wstrb[h*SW +: SW], s_wlast[h]});
    // AR
    ar_open = (arq.size() == 0 || m_arready);
    ar_g = ar_open && s_arvalid != 2'b00;
    ar_win = (s_arvalid == 2'b11) ? ptr_ar : (s_arvalid[1] ? 1 : 0);
    exp_r = ar_g ? 2'(1 << ar_win) : 2'b00;
    check_eq("s_arready", s_arready, exp_r);
    check_eq("m_arvalid", m_arvalid, arq.size() != 0);
    if (arq.size() != 0)
      check_eq("m_ar_fields", {m_arid, m_araddr, m_arlen, m_arburst},
               {arq[0].idx, arq[0].id, arq[0].addr, arq[0].len, arq[0].burst});
    // B/R steering by ID MSB
    check_eq("s_bvalid", s_bvalid, m_bvalid ? 2'(1 << m_bid[IW-1]) : 2'b00);
    check_eq("m_bready", m_bready, s_bready[m_bid[IW-1]]);
    check_eq("s_b_fields", {s_bid, s_bresp}, {m_bid[SIW-1:0], m_bresp});
    check_eq("s_rvalid", s_rvalid, m_rvalid ? 2'(1 << m_rid[IW-1]) : 2'b00);
    check_eq("m_rready", m_rready, s_rready[m_rid[IW-1]]);
    check_eq("s_r_fields", {s_rid, s_rresp, s_rlast, s_rdata},
             {m_rid[SIW-1:0], m_rresp, m_rlast, m_rdata});
    // advance model to the state after the coming edge
    if (awq.size() != 0 && m_awready) void'(awq.pop_front());
    if (aw_g) begin
      e.idx = aw_win[0]; e.id = aw_id[aw_win]; e.addr = aw_addr[aw_win];
      e.len = aw_len[aw_win]; e.burst = aw_burst[aw_win];
      awq.push_back(e);
      if (s_awvalid == 2'b11) ptr_aw = 1 - ptr_aw;
    end
    if (exp_mwv && m_wready && s_wlast[h]) void'(wfo.pop_front());
    if (aw_g) wfo.push_back(aw_win);
    if (arq.size() != 0 && m_arready) void'(arq.pop_front());
    if (ar_g) begin
      e.idx = ar_win[0]; e.id = ar_id[ar_win]; e.addr = ar_addr[ar_win];
      e.len = ar_len[ar_win]; e.burst = ar_burst[ar_win];
      arq.push_back(e);
      if (s_arvalid == 2'b11) ptr_ar = 1 - ptr_ar;
    end
    for (int i = 0; i < 2; i++) begin
      aw_hs[i] = s_awvalid[i] && s_awready[i];
      ar_hs[i] = s_arvalid[i] && s_arready[i];
      w_hs[i] = s_wvalid[i] && s_wready[i];
    end
  endtask

  initial begin
    clear_all();
    s_awvalid = 2'b11; s_arvalid = 2'b11; m_bvalid = 1; m_rvalid = 1; m_awready = 1;
    #2 check_in_reset("por");
    clear_all();
    @(negedge mem_clock); @(negedge mem_clock);
    mem_reset = 0;
    @(posedge mem_clock); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        // abandon whatever burst is in flight
        new_stimulus();
        m_bvalid = 1; m_rvalid = 1;
        mem_reset = 1;
        #1 check_in_reset("mid");
        clear_all();
        @(negedge mem_clock); @(negedge mem_clock);
        mem_reset = 0;
        @(posedge mem_clock); #1;
      end
      new_stimulus();
      @(negedge mem_clock);
      check_and_model();
      @(posedge mem_clock); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
